multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the shared multicycle MIPS datapath: one memory, one ALU, IR/MDR/A/B/ALUOut regs.
//  Issues per-state control for fetch, decode, execute, memory and writeback of
//  LW, SW, BEQ, BNE, J, JAL, JR, ADDI, ANDI and R-type (ADD, SUB, AND, OR, SLT).
//  Stalls on a memory-ready handshake; flags unsupported opcodes and recovers to fetch.
// PARAMETERS
//  ST_W       4   width of state register / state debug output
// PORTS
//  clk           in   1  system clock, all state updates on rising edge
//  rst           in   1  synchronous, active-high reset
//  opcode        in   6  IR[31:26], valid from DECODE onward
//  func          in   6  IR[5:0]
//  zero          in   1  ALU zero flag (A-B) during BRANCH
//  mem_ready     in   1  memory completes current access this cycle
//  pc_write      out  1  load PC
//  iord          out  1  mem addr: 0=PC, 1=ALUOut
//  mem_read      out  1  memory read request
//  mem_write     out  1  memory write request
//  ir_write      out  1  load IR from memory
//  reg_dst       out  2  write reg: 00=rt, 01=rd, 10=$31
//  mem_to_reg    out  2  write data: 00=ALUOut, 01=MDR, 10=PC
//  reg_write     out  1  register-file write enable
//  alu_src_a     out  1  0=PC, 1=A
//  alu_src_b     out  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
//  alu_operation out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  pc_src        out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (JR)
//  illegal_op    out  1  one-cycle pulse on unsupported opcode/func
//  state         out  ST_W  current state (debug)
// BEHAVIOUR
//  States: FETCH0 DECODE1 MEM_ADDR2 MEM_RD3 MEM_WB4 MEM_WR5 R_EX6 R_WB7 BRANCH8
//   JUMP9 I_EX10 I_WB11 JAL12 JR13 ILLEGAL14; 15 unreachable -> FETCH.
//  Reset: state=FETCH; while rst=1 every control output is 0 (incl. mem_read).
//  Default every output 0 unless listed; alu_operation default 010.
//  FETCH: mem_read=1,iord=0,src_a=0,src_b=01,add,pc_src=00; ir_write=pc_write=mem_ready;
//   stay in FETCH until mem_ready=1, then DECODE.
//  DECODE: src_a=0,src_b=11,add (branch target to ALUOut). Next by opcode:
//   LW/SW->MEM_ADDR, 000000->R_EX (func 001000 ->JR), BEQ/BNE->BRANCH, J->JUMP,
//   JAL->JAL, ADDI/ANDI->I_EX, other->ILLEGAL.
//  MEM_ADDR: src_a=1,src_b=10,add; LW->MEM_RD, SW->MEM_WR.
//  MEM_RD: mem_read=1,iord=1; hold until mem_ready, then MEM_WB.
//  MEM_WB: reg_dst=00,mem_to_reg=01,reg_write=1 -> FETCH.
//  MEM_WR: mem_write=1,iord=1; hold until mem_ready, then FETCH.
//  R_EX: src_a=1,src_b=00; func 100000 add,100010 sub,100100 and,100101 or,101010 slt;
//   other func -> ILLEGAL instead of R_WB.
//  R_WB: reg_dst=01,mem_to_reg=00,reg_write=1 -> FETCH.
//  BRANCH: src_a=1,src_b=00,sub,pc_src=01; pc_write=zero(BEQ) / ~zero(BNE) -> FETCH.
//  JUMP: pc_src=10,pc_write=1 -> FETCH.
//  JAL: pc_src=10,pc_write=1,reg_dst=10,mem_to_reg=10,reg_write=1 -> FETCH
//   (register write uses PC+4 value present before edge).
//  JR: pc_src=11,pc_write=1 -> FETCH.
//  I_EX: src_a=1,src_b=10; ADDI add, ANDI and (sign-extended imm) -> I_WB.
//  I_WB: reg_dst=00,mem_to_reg=00,reg_write=1 -> FETCH.
//  ILLEGAL: illegal_op=1 for exactly this cycle, no writes -> FETCH.
//  Cycles incl. fetch, zero wait: LW 5, SW/R/I 4, BEQ/BNE/J/JAL/JR 3; +1 per mem_ready=0 cycle.
//  mem_read/mem_write held stable while waiting; never both 1 in one cycle.
//  rst mid-instruction: next cycle FETCH, no reg/mem/PC write in the rst cycle.
// TESTING
//  rst=1 2 cycles, mem_ready=1 -> all outputs 0, then state 0,1 with pc_write=ir_write=1 in FETCH.
//  LW, mem_ready=1 -> states 0,1,2,3,4,0; reg_write only in state 4 with mem_to_reg=01.
//  SW with mem_ready low 3 cycles in MEM_WR -> mem_write=1 held 4 cycles, state 5 then 0.
//  BEQ zero=1 -> pc_write=1,pc_src=01 in BRANCH; BNE zero=1 -> pc_write=0.
//  R-type func=100010 -> alu_operation=110 in R_EX; func=000111 -> illegal_op 1 cycle, back to FETCH.
//  JAL -> reg_dst=10,mem_to_reg=10,reg_write=1,pc_write=1 same cycle; rst asserted in MEM_RD -> FETCH, no writes.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore control FSM for a shared-resource multicycle MIPS datapath (one memory,
// one ALU, IR/MDR/A/B/ALUOut registers). Steps each instruction through fetch,
// decode, execute, memory and writeback. Stalls on i_mem_ready, flags
// unsupported opcodes/funcs with a one-cycle o_illegal_op pulse, then refetches.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_opcode, i_func      IR[31:26], IR[5:0] (valid from DECODE onward)
//   i_zero                ALU zero flag, used in BRANCH
//   i_mem_ready           memory completes the current access this cycle
//   o_pc_write ... o_pc_src   datapath controls (see state table)
//   o_illegal_op          one-cycle pulse in ILLEGAL
//   o_state               current state, debug only
//
// state     | meaning
// FETCH     | read instr at PC, PC+4 -> PC and IR load when memory ready
// DECODE    | PC + (sext imm << 2) -> ALUOut, dispatch on opcode
// MEM_ADDR  | A + sext imm -> ALUOut (LW/SW address)
// MEM_RD    | read memory at ALUOut into MDR
// MEM_WB    | MDR -> rt
// MEM_WR    | write B to memory at ALUOut
// R_EX      | A op B, op from func
// R_WB      | ALUOut -> rd
// BRANCH    | A - B, take ALUOut on zero (BEQ) / not zero (BNE)
// JUMP      | jump target -> PC
// I_EX      | A op sext imm (ADDI/ANDI)
// I_WB      | ALUOut -> rt
// JAL       | jump target -> PC, PC (already PC+4) -> $31
// JR        | A -> PC
// ILLEGAL   | pulse o_illegal_op, no writes
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int ST_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [5:0]      i_opcode,
    input  logic [5:0]      i_func,
    input  logic            i_zero,
    input  logic            i_mem_ready,
    output logic            o_pc_write,
    output logic            o_iord,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_ir_write,
    output logic [1:0]      o_reg_dst,
    output logic [1:0]      o_mem_to_reg,
    output logic            o_reg_write,
    output logic            o_alu_src_a,
    output logic [1:0]      o_alu_src_b,
    output logic [2:0]      o_alu_operation,
    output logic [1:0]      o_pc_src,
    output logic            o_illegal_op,
    output logic [ST_W-1:0] o_state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EX     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EX     = 4'd10,
        I_WB     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13,
        ILLEGAL  = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    logic       w_rfunc_ok;
    logic [2:0] w_rfunc_op;

    // R-type function decode, shared by the R_EX output and its next-state choice
    always_comb begin
        w_rfunc_ok = 1'b1;
        w_rfunc_op = ALU_ADD;
        case (i_func)
            6'b100000: w_rfunc_op = ALU_ADD;
            6'b100010: w_rfunc_op = ALU_SUB;
            6'b100100: w_rfunc_op = ALU_AND;
            6'b100101: w_rfunc_op = ALU_OR;
            6'b101010: w_rfunc_op = ALU_SLT;
            default:   w_rfunc_ok = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:    if (i_mem_ready) r_state <= DECODE;
                DECODE: begin
                    case (i_opcode)
                        OP_LW, OP_SW:    r_state <= MEM_ADDR;
                        OP_RTYPE:        r_state <= (i_func == FN_JR) ? JR : R_EX;
                        OP_BEQ, OP_BNE:  r_state <= BRANCH;
                        OP_J:            r_state <= JUMP;
                        OP_JAL:          r_state <= JAL;
                        OP_ADDI, OP_ANDI: r_state <= I_EX;
                        default:         r_state <= ILLEGAL;
                    endcase
                end
                MEM_ADDR: begin
                    if (i_opcode == OP_LW)      r_state <= MEM_RD;
                    else if (i_opcode == OP_SW) r_state <= MEM_WR;
                    else                        r_state <= FETCH;
                end
                MEM_RD:   if (i_mem_ready) r_state <= MEM_WB;
                MEM_WR:   if (i_mem_ready) r_state <= FETCH;
                R_EX:     r_state <= w_rfunc_ok ? R_WB : ILLEGAL;
                I_EX:     r_state <= I_WB;
                // MEM_WB, R_WB, BRANCH, JUMP, I_WB, JAL, JR, ILLEGAL and the
                // unused encoding 15 all return to fetch
                default:  r_state <= FETCH;
            endcase
        end
    end

    // Outputs decode from state; i_mem_ready and i_zero gate the PC/IR loads
    // in the same cycle, and an asserted reset forces every control low.
    always_comb begin
        o_pc_write      = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_reg_dst       = 2'b00;
        o_mem_to_reg    = 2'b00;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_alu_operation = ALU_ADD;
        o_pc_src        = 2'b00;
        o_illegal_op    = 1'b0;
        if (i_rst) begin
            o_alu_operation = 3'b000;
        end else begin
            case (r_state)
                FETCH: begin
                    o_mem_read  = 1'b1;
                    o_alu_src_b = 2'b01;
                    o_ir_write  = i_mem_ready;
                    o_pc_write  = i_mem_ready;
                end
                DECODE:   o_alu_src_b = 2'b11;
                MEM_ADDR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    o_mem_read = 1'b1;
                    o_iord     = 1'b1;
                end
                MEM_WB: begin
                    o_mem_to_reg = 2'b01;
                    o_reg_write  = 1'b1;
                end
                MEM_WR: begin
                    o_mem_write = 1'b1;
                    o_iord      = 1'b1;
                end
                R_EX: begin
                    o_alu_src_a     = 1'b1;
                    o_alu_operation = w_rfunc_op;
                end
                R_WB: begin
                    o_reg_dst   = 2'b01;
                    o_reg_write = 1'b1;
                end
                BRANCH: begin
                    o_alu_src_a     = 1'b1;
                    o_alu_operation = ALU_SUB;
                    o_pc_src        = 2'b01;
                    o_pc_write      = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
                end
                JUMP: begin
                    o_pc_src   = 2'b10;
                    o_pc_write = 1'b1;
                end
                JAL: begin
                    // PC already holds PC+4 from fetch, so it is the link value
                    o_pc_src     = 2'b10;
                    o_pc_write   = 1'b1;
                    o_reg_dst    = 2'b10;
                    o_mem_to_reg = 2'b10;
                    o_reg_write  = 1'b1;
                end
                JR: begin
                    o_pc_src   = 2'b11;
                    o_pc_write = 1'b1;
                end
                I_EX: begin
                    o_alu_src_a     = 1'b1;
                    o_alu_src_b     = 2'b10;
                    o_alu_operation = (i_opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
                end
                I_WB:     o_reg_write  = 1'b1;
                ILLEGAL:  o_illegal_op = 1'b1;
                default: begin
                end
            endcase
        end
    end

    assign o_state = ST_W'(r_state);

endmodule
